// File: rtl/switch_matrix_cfg_loader.sv
// Serial configuration loader for the 18-wire routing switch matrix.
// Hunts for a sync word, shifts one driver-select code per wire into a
// shadow register, then commits every code to cfg_sel in a single cycle.
// A select code of zero leaves its wire undriven (high-Z).
// Optional build macro: CFG_LOADER_PARITY_EN adds a trailing even-parity
// bit per frame; a failing frame is dropped and raises the sticky err flag.
module switch_matrix_cfg_loader #(
  parameter int         NUM_WIRES = 18,
  parameter int         SEL_W     = 5,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  output logic [NUM_WIRES*SEL_W-1:0] cfg_sel,
  output logic                       cfg_loaded,
  output logic                       busy,
  output logic                       err
);

  localparam int TOT_W  = NUM_WIRES * SEL_W;
  localparam int IDX_W  = $clog2(TOT_W);
  localparam int WIRE_W = (NUM_WIRES > 1) ? $clog2(NUM_WIRES) : 1;
  localparam int POS_W  = (SEL_W > 1) ? $clog2(SEL_W) : 1;
  localparam logic [WIRE_W-1:0] LAST_WIRE = WIRE_W'(NUM_WIRES - 1);
  localparam logic [POS_W-1:0]  TOP_POS   = POS_W'(SEL_W - 1);

`ifdef CFG_LOADER_PARITY_EN
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_PARITY = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;
`endif

  // Running even-parity accumulator step.
  function automatic logic par_fold(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  state_e             state_q, state_d;
  logic [7:0]         hist_q, hist_d;
  logic [WIRE_W-1:0]  wire_q, wire_d;   // wire currently being filled (0-based)
  logic [POS_W-1:0]   pos_q, pos_d;     // bit position inside that code, MSB first
  logic [TOT_W-1:0]   shadow_q, shadow_d;
  logic [TOT_W-1:0]   sel_q, sel_d;
  logic               loaded_q, loaded_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
`ifdef CFG_LOADER_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               accept_s;
  logic [7:0]         hist_shift_s;
  logic [IDX_W-1:0]   idx_s;

  assign accept_s     = bit_valid & ready_q;
  assign hist_shift_s = {hist_q[6:0], bit_in};
  assign idx_s        = IDX_W'(wire_q) * IDX_W'(SEL_W) + IDX_W'(pos_q);

  // Next-state logic: sync hunt, payload shift, optional parity, commit.
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    wire_d   = wire_q;
    pos_d    = pos_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    loaded_d = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
`ifdef CFG_LOADER_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (accept_s) begin
          hist_d = hist_shift_s;
          if (hist_shift_s == SYNC_WORD) begin
            state_d = ST_LOAD;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            wire_d  = {WIRE_W{1'b0}};
            pos_d   = TOP_POS;
`ifdef CFG_LOADER_PARITY_EN
            par_d   = 1'b0;
`endif
          end else begin
            state_d = ST_HUNT;
          end
        end else begin
          hist_d = hist_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          shadow_d[idx_s] = bit_in;
`ifdef CFG_LOADER_PARITY_EN
          par_d = par_fold(par_q, bit_in);
`endif
          if ((wire_q == LAST_WIRE) && (pos_q == {POS_W{1'b0}})) begin
`ifdef CFG_LOADER_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_COMMIT;
`endif
          end else if (pos_q == {POS_W{1'b0}}) begin
            wire_d = wire_q + WIRE_W'(1);
            pos_d  = TOP_POS;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef CFG_LOADER_PARITY_EN
      ST_PARITY: begin
        if (accept_s) begin
          if (par_fold(par_q, bit_in) == 1'b0) begin
            state_d = ST_COMMIT;
          end else begin
            // Corrupt frame: drop it, keep the previous selects.
            state_d = ST_HUNT;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            hist_d  = 8'h00;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_COMMIT: begin
        sel_d    = shadow_q;
        loaded_d = 1'b1;
        busy_d   = 1'b0;
        hist_d   = 8'h00;
        state_d  = ST_HUNT;
      end
      default: begin
        state_d = ST_HUNT;
        busy_d  = 1'b0;
        hist_d  = 8'h00;
      end
    endcase
    ready_d = (state_d != ST_COMMIT);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      hist_q   <= 8'h00;
      wire_q   <= {WIRE_W{1'b0}};
      pos_q    <= {POS_W{1'b0}};
      shadow_q <= {TOT_W{1'b0}};
      sel_q    <= {TOT_W{1'b0}};
      loaded_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
`ifdef CFG_LOADER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      wire_q   <= wire_d;
      pos_q    <= pos_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      loaded_q <= loaded_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
`ifdef CFG_LOADER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bit_ready  = ready_q;
  assign cfg_sel    = sel_q;
  assign cfg_loaded = loaded_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_switch_matrix_cfg_loader.sv
// Bench for switch_matrix_cfg_loader: a stream-level model (sync search over
// the accepted bit history, payload queue decoded into per-wire codes) is
// compared against every DUT output each cycle, plus hand-computed literals.
module tb_switch_matrix_cfg_loader;

  localparam int TW = 90;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [TW-1:0] cfg_sel;
  logic          cfg_loaded;
  logic          busy;
  logic          err;

  switch_matrix_cfg_loader dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .cfg_sel(cfg_sel), .cfg_loaded(cfg_loaded),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int n_loaded = 0;
  bit stall_en = 1'b0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_on = 1'b0;
  bit            m_loading, m_par_phase, m_commit;
  int            m_hist;
  bit            m_bits[$];
  logic [TW-1:0] m_pend;
  logic [TW-1:0] exp_sel;
  bit            exp_loaded, exp_busy, exp_err, exp_ready;

  task automatic model_edge();
    int ones;
    int code;
    if (rst) begin
      m_on = 1'b1; m_loading = 1'b0; m_par_phase = 1'b0; m_commit = 1'b0;
      m_hist = 0; m_bits.delete(); m_pend = '0;
      exp_sel = '0; exp_loaded = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_ready = 1'b1;
    end else if (m_on) begin
      exp_loaded = 1'b0;
      if (m_commit) begin
        exp_sel = m_pend; exp_loaded = 1'b1; exp_busy = 1'b0;
        m_hist = 0; m_commit = 1'b0; exp_ready = 1'b1;
      end else if (bit_valid && exp_ready) begin
        if (m_par_phase) begin
          m_par_phase = 1'b0;
          ones = int'(bit_in);
          foreach (m_bits[i]) ones += int'(m_bits[i]);
          if (ones % 2 == 0) begin
            m_commit = 1'b1; exp_ready = 1'b0;
          end else begin
            exp_err = 1'b1; exp_busy = 1'b0; m_hist = 0;
          end
        end else if (m_loading) begin
          m_bits.push_back(bit_in);
          if (m_bits.size() == TW) begin
            m_loading = 1'b0;
            for (int w = 0; w < 18; w++) begin
              code = 0;
              for (int j = 0; j < 5; j++) code = code * 2 + int'(m_bits[w*5 + j]);
              m_pend[w*5 +: 5] = code[4:0];
            end
`ifdef CFG_LOADER_PARITY_EN
            m_par_phase = 1'b1;
`else
            m_commit = 1'b1; exp_ready = 1'b0;
`endif
          end
        end else begin
          m_hist = (m_hist * 2 + int'(bit_in)) % 256;
          if (m_hist == 165) begin
            m_loading = 1'b1; exp_busy = 1'b1; exp_err = 1'b0; m_bits.delete();
          end
        end
      end
    end
  endtask

  // Model update on the clock edge, full output comparison mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (m_on) begin
        chk("cfg_sel",    cfg_sel,    exp_sel);
        chk("cfg_loaded", cfg_loaded, exp_loaded);
        chk("busy",       busy,       exp_busy);
        chk("err",        err,        exp_err);
        chk("bit_ready",  bit_ready,  exp_ready);
        if (cfg_loaded === 1'b1) n_loaded++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b);
    if (stall_en && ($urandom_range(0, 1) == 1)) idle(int'($urandom_range(1, 3)));
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic send_payload(input logic [TW-1:0] sel, input int nbits);
    for (int k = 0; k < nbits; k++) drive_bit(sel[(k/5)*5 + 4 - (k%5)]);
  endtask

  // Full frame with correct parity (when enabled); one idle slot covers COMMIT.
  task automatic send_frame(input logic [TW-1:0] sel);
    send_byte(8'hA5);
    send_payload(sel, TW);
`ifdef CFG_LOADER_PARITY_EN
    drive_bit(^sel);
`endif
    idle(1);
  endtask

  logic [TW-1:0] sel_a, sel_b, sel_c, sel_e;
  int            n0;

  initial begin
    sel_a = 90'd7  << 45;             // wire 10 = 00111
    sel_b = 90'd16;                   // wire 1  = 10000
    sel_c = 90'd20 | (90'd20 << 5);   // wires 1,2 = 10100: payload holds 10100101
    sel_e = 90'd31 << 85;             // wire 18 = 11111

    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(10);
    chk("reset_sel",    cfg_sel, 90'h0);
    chk("reset_loaded", cfg_loaded, 1'b0);
    chk("reset_busy",   busy, 1'b0);
    chk("reset_ready",  bit_ready, 1'b1);

    // Frame A with explicit latency checks around the final bit.
    n0 = n_loaded;
    send_byte(8'hA5);
    send_payload(sel_a, TW);
`ifdef CFG_LOADER_PARITY_EN
    drive_bit(^sel_a);
`endif
    @(negedge clk); bit_valid = 1'b0;
    chk("lat1_loaded", cfg_loaded, 1'b0);
    chk("lat1_sel",    cfg_sel, 90'h0);
    chk("lat1_ready",  bit_ready, 1'b0);
    @(negedge clk);
    chk("lat2_loaded", cfg_loaded, 1'b1);
    chk("lat2_sel",    cfg_sel, sel_a);
    chk("lat2_busy",   busy, 1'b0);
    idle(3);
    chk("a_sel_field", cfg_sel[49:45], 5'b00111);
    chk("a_pulses",    n_loaded - n0, 1);

    // Same frame with random stalls.
    n0 = n_loaded;
    stall_en = 1'b1;
    send_frame(sel_a);
    stall_en = 1'b0;
    idle(3);
    chk("stall_sel",    cfg_sel, sel_a);
    chk("stall_pulses", n_loaded - n0, 1);

    // Junk bytes must not sync.
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(1);
    chk("junk_busy", busy, 1'b0);
    send_frame(sel_b);
    idle(3);
    chk("junk_sel", cfg_sel, sel_b);

    // Back-to-back frames; first payload contains the sync pattern.
    n0 = n_loaded;
    send_frame(sel_c);
    send_byte(8'hA5);
    idle(1);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_sel_c", cfg_sel, sel_c);
    send_payload(sel_a, TW);
`ifdef CFG_LOADER_PARITY_EN
    drive_bit(^sel_a);
`endif
    idle(4);
    chk("b2b_sel_a",  cfg_sel, sel_a);
    chk("b2b_pulses", n_loaded - n0, 2);

    // Reset in the middle of a frame.
    send_byte(8'hA5);
    send_payload(sel_e, 40);
    @(negedge clk); bit_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_sel",  cfg_sel, 90'h0);
    chk("mid_rst_busy", busy, 1'b0);
    send_frame(sel_e);
    idle(3);
    chk("rst_frame_sel", cfg_sel, sel_e);

`ifdef CFG_LOADER_PARITY_EN
    // Bad parity: frame dropped, err raised.
    n0 = n_loaded;
    send_byte(8'hA5);
    send_payload(sel_a, TW);
    drive_bit(1'b0);
    idle(3);
    chk("par_bad_err",    err, 1'b1);
    chk("par_bad_sel",    cfg_sel, sel_e);
    chk("par_bad_pulses", n_loaded - n0, 0);
    send_byte(8'hA5);
    idle(1);
    chk("par_err_clear", err, 1'b0);
    send_payload(sel_a, TW);
    drive_bit(1'b1);
    idle(4);
    chk("par_good_sel",    cfg_sel, sel_a);
    chk("par_good_pulses", n_loaded - n0, 1);
`else
    chk("err_tied", err, 1'b0);
`endif

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
